dvs_multi_event_to_ravens: RTL and testbench
============================================

DVS_MULTI_EVENT_TO_RAVENS -- requirements
Module: dvs_multi_event_to_ravens

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of FIFO event-queue channels, 1..16.
REQ-002 SHALL have parameter EVENT_BITS, default dvs_ravens_pkg::EVENT_BITS: event width; timestamp is bits [TS_BITS-1:0].
REQ-003 SHALL have parameter TS_BITS, default dvs_ravens_pkg::TIMESTAMP_US_BITS: timestamp width in us.
REQ-004 SHALL have parameter BUF_DEPTH, default 4: spike buffer entries, power of two, at least 2.
REQ-005 SHALL have parameter GRANT_TIMEOUT, default 15: cycles to wait for a grant before skipping a channel.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port fifo_grant, input, NUM_CH: per-channel bus grant.
REQ-009 SHALL have port fifo_event, input, NUM_CH*EVENT_BITS: channel c occupies bits [c*EVENT_BITS +: EVENT_BITS].
REQ-010 SHALL have port time_us, input, TS_BITS: free-running us time, wraps.
REQ-011 SHALL have port fifo_req, output, NUM_CH: one-hot or zero bus request.
REQ-012 SHALL have port fifo_rd_en, output, NUM_CH: one-hot or zero read enable.
REQ-013 SHALL have port pkt_valid, output, 1: pkt_data holds a released spike.
REQ-014 SHALL have port pkt_ready, input, 1: downstream accepts pkt_data.
REQ-015 SHALL have port pkt_data, output, CH_BITS+EVENT_BITS: {channel index, event}, with CH_BITS = max(1, clog2(NUM_CH)).

Function
REQ-016 Reader FSM states SHALL be IDLE, REQ, READ_CTRL, READ.
REQ-017 IDLE SHALL move to REQ on the current channel when the buffer holds fewer than BUF_DEPTH-1 entries.
REQ-018 In REQ, fifo_req[ch] SHALL be 1 and a wait counter SHALL increment.
REQ-019 REQ SHALL go to READ_CTRL on fifo_grant[ch]=1.
REQ-020 REQ SHALL go to IDLE and advance ch when the wait counter reaches GRANT_TIMEOUT without a grant.
REQ-021 READ_CTRL SHALL assert fifo_rd_en[ch] for exactly one cycle, then go to READ.
REQ-022 READ SHALL capture fifo_event[ch] into the buffer tail, advance ch round-robin (NUM_CH-1 wraps to 0), and return to IDLE.
REQ-023 Grants on channels other than ch SHALL be ignored.
REQ-024 Only the buffer head is a release candidate; this is in-order FIFO release with no reordering.
REQ-025 The head SHALL be released when ((time_us - head_ts) mod 2^TS_BITS) < 2^(TS_BITS-1); this comparison is wrap-aware.
REQ-026 Release SHALL drive pkt_valid=1 from a registered output stage with pkt_data = {source ch, event}.
REQ-027 pkt_data SHALL be stable while pkt_valid=1 and pkt_ready=0.
REQ-028 A transfer occurs on a cycle with pkt_valid and pkt_ready both 1; the next released entry may be presented the following cycle, for a throughput of 1 per cycle.
REQ-029 Write and pop on the same cycle SHALL both occur; occupancy is unchanged.
REQ-030 The occupancy guard in REQ-017 SHALL make buffer overflow impossible.
REQ-031 Latency from the READ edge to pkt_valid SHALL be 2 cycles minimum when the timestamp is already due.
REQ-032 With NUM_CH=1, ch SHALL stay at 0.

Reset
REQ-033 When rst=1, independent of clk, the FSM SHALL be IDLE, ch=0, wait counter 0, and buffer empty.
REQ-034 When rst=1, fifo_req=0, fifo_rd_en=0, pkt_valid=0, and pkt_data=0.
REQ-035 A reset mid-handshake SHALL drop an in-flight read without asserting fifo_rd_en afterwards.
REQ-036 On rst deassertion, the first request SHALL go to channel 0 on the next cycle at earliest.

Verification
REQ-037 Four channels, all grants tied high, each event ts=time_us-1 -> fifo_rd_en pulses on ch 0,1,2,3,0 in order, each one cycle wide; pkt_data channel field follows the same sequence.
REQ-038 Grant on ch1 withheld -> fifo_req[1] held 16 cycles, then the FSM moves to ch2; no fifo_rd_en[1].
REQ-039 Event ts=100 read at time_us=90 -> pkt_valid stays 0 until time_us=100, then rises.
REQ-040 ts=0x0002 with TS_BITS=16 and time_us=0xFFFE -> held; released after time_us wraps to 0x0002.
REQ-041 pkt_ready=0 for 50 cycles with events due -> at most 3 buffered, no further fifo_req, pkt_data stable; ready=1 drains in order.
REQ-042 rst=1 asserted during READ_CTRL -> all outputs 0 immediately; after release, the first fifo_req is on ch0.

Source files
------------

// File: rtl/dvs_multi_event_to_ravens.sv
// Multi-channel DVS event reader: polls per-channel event FIFOs round-robin
// over a request/grant bus, buffers the events, and releases each one as a
// {channel, event} packet once its timestamp is due. Release is in order.

package dvs_ravens_pkg;
    localparam int EVENT_BITS        = 32;
    localparam int TIMESTAMP_US_BITS = 16;
endpackage

module dvs_multi_event_to_ravens #(
    parameter int NUM_CH        = 4,
    parameter int EVENT_BITS    = dvs_ravens_pkg::EVENT_BITS,
    parameter int TS_BITS       = dvs_ravens_pkg::TIMESTAMP_US_BITS,
    parameter int BUF_DEPTH     = 4,
    parameter int GRANT_TIMEOUT = 15,
    localparam int CH_BITS      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             fifo_grant,
    input  logic [NUM_CH*EVENT_BITS-1:0]  fifo_event,
    input  logic [TS_BITS-1:0]            time_us,
    output logic [NUM_CH-1:0]             fifo_req,
    output logic [NUM_CH-1:0]             fifo_rd_en,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic [CH_BITS+EVENT_BITS-1:0] pkt_data
);

    localparam int PTR_BITS  = $clog2(BUF_DEPTH);
    localparam int CNT_BITS  = PTR_BITS + 1;
    localparam int WAIT_BITS = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;

    localparam logic [CNT_BITS-1:0]  GUARD    = CNT_BITS'(BUF_DEPTH - 1);
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
    localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(GRANT_TIMEOUT);
    localparam logic [CH_BITS-1:0]   LAST_CH  = CH_BITS'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0]    ONE_HOT0 = NUM_CH'(1);

    typedef enum logic [1:0] {IDLE, REQ, READ_CTRL, READ} state_t;

    typedef struct packed {
        logic [CH_BITS-1:0]    ch;
        logic [EVENT_BITS-1:0] ev;
    } entry_t;

    state_t                state;
    logic [CH_BITS-1:0]    ch;
    logic [CH_BITS-1:0]    next_ch;
    logic [WAIT_BITS-1:0]  wait_cnt;
    logic [EVENT_BITS-1:0] rd_event;

    entry_t                buf_mem [BUF_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [CNT_BITS-1:0]   count;
    logic                  wr;

    logic                  xfer;
    logic [PTR_BITS-1:0]   cand_idx;
    logic                  cand_avail;
    entry_t                cand;
    logic [TS_BITS-1:0]    cand_age;
    logic                  cand_due;

    // Channel pointer successor and the selected channel's event word
    always_comb begin
        next_ch  = (ch == LAST_CH) ? '0 : ch + 1'b1;
        rd_event = fifo_event[int'(ch)*EVENT_BITS +: EVENT_BITS];
        wr       = (state == READ);
    end

    // Reader FSM; request/read-enable are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            wait_cnt   <= '0;
            fifo_req   <= '0;
            fifo_rd_en <= '0;
        end else begin
            fifo_rd_en <= '0;
            case (state)
                IDLE: begin
                    // the presented packet still counts, so one slot is always
                    // left for the single read that can be in flight
                    if (count < GUARD) begin
                        state    <= REQ;
                        wait_cnt <= '0;
                        fifo_req <= ONE_HOT0 << ch;
                    end
                end
                REQ: begin
                    if (fifo_grant[ch]) begin
                        state      <= READ_CTRL;
                        fifo_req   <= '0;
                        fifo_rd_en <= ONE_HOT0 << ch;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state    <= IDLE;
                        fifo_req <= '0;
                        ch       <= next_ch;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                READ_CTRL: state <= READ;
                READ: begin
                    state <= IDLE;
                    ch    <= next_ch;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Spike buffer storage; written as the FSM leaves READ
    always_ff @(posedge clk) begin
        if (wr) buf_mem[wr_ptr] <= '{ch: ch, ev: rd_event};
    end

    // Next release candidate: the head, or the entry behind it when the head
    // is leaving this cycle. Age is wrap-aware: due when time_us - ts lands in
    // the lower half of the timestamp range.
    always_comb begin
        xfer       = pkt_valid && pkt_ready;
        cand_idx   = xfer ? rd_ptr + 1'b1 : rd_ptr;
        cand_avail = xfer ? (count > CNT_ONE) : (count != '0);
        cand       = buf_mem[cand_idx];
        cand_age   = time_us - cand.ev[TS_BITS-1:0];
        cand_due   = ~cand_age[TS_BITS-1];
    end

    // Buffer pointers/occupancy and the registered packet stage; the head
    // stays in the buffer until it is accepted downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
        end else begin
            if (wr)   wr_ptr <= wr_ptr + 1'b1;
            if (xfer) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, xfer})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!pkt_valid || xfer) begin
                pkt_valid <= cand_avail && cand_due;
                if (cand_avail && cand_due) pkt_data <= cand;
            end
        end
    end

endmodule

// File: tb/tb_dvs_multi_event_to_ravens.sv
// Bench for dvs_multi_event_to_ravens: behavioural FIFO sources answer read
// enables, every produced event goes into a scoreboard, and packets leaving
// the DUT are popped and compared in order.

module tb_dvs_multi_event_to_ravens;

    localparam int NUM_CH = 4;
    localparam int EVENT_BITS = 32;
    localparam int TS_BITS = 16;
    localparam int BUF_DEPTH = 4;
    localparam int GRANT_TIMEOUT = 15;
    localparam int CH_BITS = 2;
    localparam int PKT_W = CH_BITS + EVENT_BITS;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NUM_CH-1:0]            fifo_grant = '0;
    logic [NUM_CH*EVENT_BITS-1:0] fifo_event = '0;
    logic [TS_BITS-1:0]           time_us = '0;
    logic [NUM_CH-1:0]            fifo_req;
    logic [NUM_CH-1:0]            fifo_rd_en;
    logic                         pkt_valid;
    logic                         pkt_ready = 1'b0;
    logic [PKT_W-1:0]             pkt_data;

    int vectors = 0;
    int miscompares = 0;

    logic [PKT_W-1:0] sb[$];
    int               rd_log[$];
    int               out_log[$];

    bit                 ts_rel = 1'b1;
    bit                 time_run = 1'b0;
    logic [TS_BITS-1:0] ts_abs = '0;
    int                 seq = 0;

    dvs_multi_event_to_ravens #(
        .NUM_CH(NUM_CH), .EVENT_BITS(EVENT_BITS), .TS_BITS(TS_BITS),
        .BUF_DEPTH(BUF_DEPTH), .GRANT_TIMEOUT(GRANT_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .fifo_grant(fifo_grant), .fifo_event(fifo_event),
        .time_us(time_us), .fifo_req(fifo_req), .fifo_rd_en(fifo_rd_en),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    // One clock: score a transfer that the coming edge will complete, then at
    // the falling edge let the FIFO sources answer read enables.
    task automatic tick();
        logic [EVENT_BITS-1:0] ev;
        logic [PKT_W-1:0]      exp_pkt;
        if (!rst && pkt_valid && pkt_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_pop: got pkt_data=%h, required no packet", pkt_data);
            end else begin
                exp_pkt = sb.pop_front();
                if (pkt_data !== exp_pkt) begin
                    miscompares++;
                    $display("FAIL sb_data: got %h, required %h", pkt_data, exp_pkt);
                end
            end
            out_log.push_back(int'(pkt_data[PKT_W-1 -: CH_BITS]));
        end
        @(negedge clk);
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (fifo_rd_en[c]) begin
                    seq++;
                    ev[EVENT_BITS-1:TS_BITS] = 16'(seq);
                    ev[TS_BITS-1:0] = ts_rel ? time_us - 16'd1 : ts_abs;
                    fifo_event[c*EVENT_BITS +: EVENT_BITS] = ev;
                    rd_log.push_back(c);
                    sb.push_back({CH_BITS'(c), ev});
                end
            end
        end
        if (time_run) time_us = time_us + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_grant = '0;
        pkt_ready = 1'b0;
        time_run = 1'b0;
        ts_rel = 1'b1;
        repeat (2) tick();
        sb.delete();
        rd_log.delete();
        out_log.delete();
        fifo_event = '0;
        rst = 1'b0;
    endtask

    task automatic drain();
        fifo_grant = '0;
        pkt_ready = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fifo_grant = '0;
        repeat (2) tick();
        vectors++;
        if (fifo_req !== '0) begin miscompares++; $display("FAIL rst_req: got %b, required 0000", fifo_req); end
        vectors++;
        if (fifo_rd_en !== '0) begin miscompares++; $display("FAIL rst_rd_en: got %b, required 0000", fifo_rd_en); end
        vectors++;
        if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", pkt_valid); end
        vectors++;
        if (pkt_data !== '0) begin miscompares++; $display("FAIL rst_data: got %h, required 0", pkt_data); end
        rst = 1'b0;
        tick();
        vectors++;
        if (fifo_req !== 4'b0001) begin miscompares++; $display("FAIL first_req: got %b, required 0001", fifo_req); end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        logic [NUM_CH-1:0] prev_rd = '0;
        int first_rd = -1;
        int first_pv = -1;
        do_reset();
        fifo_grant = '1;
        pkt_ready = 1'b1;
        time_us = 16'h1000;
        time_run = 1'b1;
        for (int i = 0; i < 200 && out_log.size() < 5; i++) begin
            tick();
            if (fifo_rd_en != '0) begin
                vectors++;
                if ($countones(fifo_rd_en) != 1 || fifo_rd_en === prev_rd) begin
                    miscompares++;
                    $display("FAIL rd_en_pulse: got %b (prev %b), required single one-cycle bit", fifo_rd_en, prev_rd);
                end
                if (first_rd < 0) first_rd = i;
            end
            if (pkt_valid && first_pv < 0) first_pv = i;
            prev_rd = fifo_rd_en;
        end
        vectors++;
        if (first_pv - first_rd != 3) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles rd_en->valid, required 3", first_pv - first_rd);
        end
        vectors++;
        if (out_log.size() < 5 || rd_log.size() < 5) begin
            miscompares++;
            $display("FAIL rr_timeout: got %0d reads / %0d packets, required 5", rd_log.size(), out_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                vectors++;
                if (rd_log[k] != exp_seq[k] || out_log[k] != exp_seq[k]) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: got rd ch %0d pkt ch %0d, required %0d", k, rd_log[k], out_log[k], exp_seq[k]);
                end
            end
        end
        drain();
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL rr_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_timeout();
        int held = 0;
        int rd1 = 0;
        do_reset();
        fifo_grant = 4'b1101;
        pkt_ready = 1'b1;
        time_run = 1'b1;
        for (int i = 0; i < 100 && !fifo_req[1]; i++) tick();
        for (int i = 0; i < 40 && fifo_req[1]; i++) begin held++; tick(); end
        vectors++;
        if (held != GRANT_TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL req1_hold: got %0d cycles, required %0d", held, GRANT_TIMEOUT + 1);
        end
        for (int i = 0; i < 10 && fifo_req == '0; i++) tick();
        vectors++;
        if (fifo_req !== 4'b0100) begin miscompares++; $display("FAIL next_req: got %b, required 0100", fifo_req); end
        foreach (rd_log[k]) if (rd_log[k] == 1) rd1++;
        vectors++;
        if (rd1 != 0) begin miscompares++; $display("FAIL no_rd_ch1: got %0d reads on ch1, required 0", rd1); end
        drain();
    endtask

    task automatic test_future_ts();
        do_reset();
        time_us = 16'd90;
        ts_rel = 1'b0;
        ts_abs = 16'd100;
        fifo_grant = 4'b0001;
        pkt_ready = 1'b1;
        for (int i = 0; i < 50 && rd_log.size() == 0; i++) tick();
        repeat (5) tick();
        vectors++;
        if (pkt_valid !== 1'b0 || rd_log.size() == 0) begin
            miscompares++;
            $display("FAIL hold_90: got valid=%b reads=%0d, required valid=0 with a read", pkt_valid, rd_log.size());
        end
        for (int v = 91; v <= 99; v++) begin
            time_us = 16'(v);
            tick();
            vectors++;
            if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL hold_%0d: got valid=%b, required 0", v, pkt_valid); end
        end
        time_us = 16'd100;
        tick();
        vectors++;
        if (pkt_valid !== 1'b1) begin miscompares++; $display("FAIL release_100: got valid=%b, required 1", pkt_valid); end
        drain();
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL future_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_wrap();
        logic [TS_BITS-1:0] hold_t[3] = '{16'hFFFF, 16'h0000, 16'h0001};
        do_reset();
        time_us = 16'hFFFE;
        ts_rel = 1'b0;
        ts_abs = 16'h0002;
        fifo_grant = 4'b0001;
        pkt_ready = 1'b1;
        for (int i = 0; i < 50 && rd_log.size() == 0; i++) tick();
        repeat (5) tick();
        vectors++;
        if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_hold_fffe: got valid=%b, required 0", pkt_valid); end
        for (int k = 0; k < 3; k++) begin
            time_us = hold_t[k];
            tick();
            vectors++;
            if (pkt_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_hold_%h: got valid=%b, required 0", hold_t[k], pkt_valid); end
        end
        time_us = 16'h0002;
        tick();
        vectors++;
        if (pkt_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_release: got valid=%b, required 1", pkt_valid); end
        drain();
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL wrap_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        fifo_grant = '1;
        time_us = 16'h2000;
        time_run = 1'b1;
        pkt_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pkt_valid) begin
                vectors++;
                if (sb.size() == 0 || pkt_data !== sb[0]) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h, required buffer head (%0d queued)", pkt_data, sb.size());
                end
            end
            if (i >= 30) begin
                vectors++;
                if (fifo_req !== '0) begin miscompares++; $display("FAIL stall_no_req: got %b, required 0000", fifo_req); end
            end
        end
        vectors++;
        if (rd_log.size() != BUF_DEPTH - 1) begin
            miscompares++;
            $display("FAIL buffer_limit: got %0d reads, required %0d", rd_log.size(), BUF_DEPTH - 1);
        end
        fifo_grant = '0;
        pkt_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin tick(); n++; end
        vectors++;
        if (n != BUF_DEPTH - 1 || pkt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_rate: got %0d cycles valid=%b, required %0d cycles valid=0", n, pkt_valid, BUF_DEPTH - 1);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (k >= out_log.size() || out_log[k] != k) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: got %0d packets, required ch %0d", k, out_log.size(), k);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fifo_grant = '1;
        pkt_ready = 1'b1;
        time_us = 16'h3000;
        time_run = 1'b1;
        for (int i = 0; i < 50 && fifo_rd_en == '0; i++) tick();
        vectors++;
        if (fifo_rd_en == '0) begin miscompares++; $display("FAIL mid_wait: got no read enable, required one"); end
        rst = 1'b1;
        #1;
        vectors++;
        if (fifo_req !== '0 || fifo_rd_en !== '0 || pkt_valid !== 1'b0 || pkt_data !== '0) begin
            miscompares++;
            $display("FAIL mid_rst_out: got req=%b rd=%b v=%b d=%h, required all 0", fifo_req, fifo_rd_en, pkt_valid, pkt_data);
        end
        fifo_grant = '0;
        repeat (2) tick();
        sb.delete();
        rd_log.delete();
        out_log.delete();
        rst = 1'b0;
        tick();
        vectors++;
        if (fifo_req !== 4'b0001) begin miscompares++; $display("FAIL post_rst_req: got %b, required 0001", fifo_req); end
        repeat (20) tick();
        vectors++;
        if (rd_log.size() != 0) begin miscompares++; $display("FAIL post_rst_rd: got %0d reads, required 0", rd_log.size()); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_timeout();
        test_future_ts();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
